// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one-outstanding word reads to instruction
// memory and queues returned words in a small FIFO for decode; handles redirects.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, ERR} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] target, target_nx;
   logic        req_nx;
   logic [31:0] addr_nx;
   logic [AW:0] count, count_nx;
   logic [AW-1:0] rd_ptr, rd_nx, wr_ptr, wr_nx;
   logic [31:0] fifo_instr [DEPTH];
   logic [31:0] fifo_pc    [DEPTH];
   logic        ack, push, pop;

   assign ack       = imem_req & imem_ack;
   assign if_valid  = (count != '0);
   assign pop       = if_valid & if_ready;
   assign if_instr  = if_valid ? fifo_instr[rd_ptr] : '0;
   assign if_pc     = if_valid ? fifo_pc[rd_ptr]    : '0;
   assign fetch_err = (state == ERR);

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      target_nx = target;
      push      = 1'b0;
      if (redirect) begin
         // An unacknowledged request must finish before the new target can be issued.
         if (imem_req && !imem_ack) begin
            state_nx  = DRAIN;
            target_nx = redirect_pc;
         end else if (redirect_pc[1:0] != 2'b00) begin
            state_nx = ERR;
         end else begin
            state_nx = RUN;
            pc_nx    = redirect_pc;
         end
      end else begin
         case (state)
            RUN: begin
               if (ack) begin
                  push  = 1'b1;
                  pc_nx = pc + 32'd4;
               end
            end
            DRAIN: begin
               if (ack) begin
                  state_nx = (target[1:0] != 2'b00) ? ERR : RUN;
                  pc_nx    = target;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      count_nx = count;
      rd_nx    = rd_ptr;
      wr_nx    = wr_ptr;
      if (redirect) begin
         count_nx = '0;
         rd_nx    = '0;
         wr_nx    = '0;
      end else begin
         count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
         rd_nx    = rd_ptr + AW'(pop);
         wr_nx    = wr_ptr + AW'(push);
      end
   end

   always_comb begin
      if (imem_req && !imem_ack) begin
         req_nx  = 1'b1;
         addr_nx = imem_addr;
      end else begin
         req_nx  = (state_nx == RUN) && (count_nx < (AW+1)'(DEPTH));
         addr_nx = pc_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         target    <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         pc        <= pc_nx;
         target    <= target_nx;
         imem_req  <= req_nx;
         imem_addr <= addr_nx;
         count     <= count_nx;
         rd_ptr    <= rd_nx;
         wr_ptr    <= wr_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table-driven streaming/backpressure rows plus
// hand-written redirect, drain, misalignment, wrap and async-reset sequences.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_err;

   int n_tests = 0;
   int n_fail  = 0;

   instruction_fetch #(.RESET_PC(32'h0040_0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   // memory model: acks after mem_delay wait cycles; force_ack injects a stray ack
   int          mem_delay = 0;
   int          mem_cnt = 0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        force_ack = 1'b0;
   assign imem_ack   = mem_ack | force_ack;
   assign imem_rdata = force_ack ? 32'hBAD0_BAD0 : mem_rdata;

   always @(posedge clk) begin
      #1;
      if (imem_req) begin
         if (mem_cnt >= mem_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = word_of(imem_addr);
            mem_cnt   = 0;
         end else begin
            mem_ack = 1'b0;
            mem_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
         mem_cnt = 0;
      end
   end

   logic [31:0] got_pc[$];
   logic [31:0] got_in[$];
   always @(negedge clk) begin
      if (rst_n && if_valid && if_ready) begin
         got_pc.push_back(if_pc);
         got_in.push_back(if_instr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   vec_t vt[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 1'b1, 32'h0040_0004, 1'b1, 32'h0040_0000};
      vt[2]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004};
      vt[3]  = '{1'b1, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0008};
      vt[4]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[5]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[6]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[7]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[8]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[9]  = '{1'b0, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0008};
      vt[10] = '{1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_000C};
      vt[11] = '{1'b1, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_0010};
      vt[12] = '{1'b1, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0014};

      // reset state
      tick();
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0040_0000);
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_err", 32'(fetch_err), 32'h0);
      rst_n = 1'b1;

      // streaming and backpressure rows
      for (int i = 0; i < 13; i++) begin
         if_ready = vt[i].rdy;
         tick();
         chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(vt[i].req));
         if (vt[i].req) chk($sformatf("row%0d_addr", i), imem_addr, vt[i].addr);
         chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vt[i].vld));
         if (vt[i].vld) begin
            chk($sformatf("row%0d_pc", i), if_pc, vt[i].pc);
            chk($sformatf("row%0d_instr", i), if_instr, word_of(vt[i].pc));
         end
      end

      // redirect while a slow request is outstanding
      mem_delay = 2;
      if_ready  = 1'b1;
      do_reset();
      tick();
      chk("drain_first_addr", imem_addr, 32'h0040_0000);
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0100;
      tick();
      redirect = 1'b0;
      chk("drain_hold_req", 32'(imem_req), 32'h1);
      chk("drain_hold_addr", imem_addr, 32'h0040_0000);
      chk("drain_valid", 32'(if_valid), 32'h0);
      tick();
      chk("drain_hold2_addr", imem_addr, 32'h0040_0000);
      tick();
      chk("drain_new_req", 32'(imem_req), 32'h1);
      chk("drain_new_addr", imem_addr, 32'h0040_0100);
      chk("drain_no_leak", 32'(if_valid), 32'h0);
      for (int k = 0; k < 10 && !if_valid; k++) tick();
      chk("drain_resume_valid", 32'(if_valid), 32'h1);
      chk("drain_resume_pc", if_pc, 32'h0040_0100);
      chk("drain_resume_instr", if_instr, word_of(32'h0040_0100));

      // misaligned redirect, then recovery
      mem_delay = 0;
      repeat (3) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0102;
      tick();
      redirect = 1'b0;
      chk("err_set", 32'(fetch_err), 32'h1);
      chk("err_valid", 32'(if_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("err_noreq%0d", k), 32'(imem_req), 32'h0);
         chk($sformatf("err_sticky%0d", k), 32'(fetch_err), 32'h1);
         tick();
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0200;
      tick();
      redirect = 1'b0;
      chk("err_clear", 32'(fetch_err), 32'h0);
      chk("err_resume_req", 32'(imem_req), 32'h1);
      chk("err_resume_addr", imem_addr, 32'h0040_0200);
      tick();
      chk("err_resume_valid", 32'(if_valid), 32'h1);
      chk("err_resume_pc", if_pc, 32'h0040_0200);

      // address wrap
      repeat (2) tick();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
      chk("wrap_flush", 32'(if_valid), 32'h0);
      got_pc.delete();
      got_in.delete();
      for (int k = 0; k < 20 && got_pc.size() < 3; k++) tick();
      chk("wrap_count", 32'(got_pc.size() >= 3), 32'h1);
      if (got_pc.size() >= 3) begin
         chk("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
         chk("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", got_pc[2], 32'h0000_0000);
         chk("wrap_in2", got_in[2], word_of(32'h0000_0000));
      end

      // async reset with a full FIFO, then a stray ack
      if_ready = 1'b0;
      repeat (4) tick();
      chk("full_valid", 32'(if_valid), 32'h1);
      chk("full_noreq", 32'(imem_req), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req), 32'h0);
      chk("arst_addr", imem_addr, 32'h0040_0000);
      chk("arst_valid", 32'(if_valid), 32'h0);
      chk("arst_instr", if_instr, 32'h0);
      chk("arst_pc", if_pc, 32'h0);
      force_ack = 1'b1;
      rst_n     = 1'b1;
      tick();
      force_ack = 1'b0;
      if_ready  = 1'b1;
      chk("stray_ack_valid", 32'(if_valid), 32'h0);
      chk("stray_ack_req", 32'(imem_req), 32'h1);
      chk("stray_ack_addr", imem_addr, 32'h0040_0000);
      tick();
      chk("post_rst_pc", if_pc, 32'h0040_0000);
      chk("post_rst_instr", if_instr, word_of(32'h0040_0000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: owns the program counter, drives word-aligned read requests into instruction memory, and buffers returned instruction words in a small FIFO for the decode stage. It sits between instruction memory, on the requester side, and decode, on the producer side. It supports branch/jump redirects with flush and in-flight response discard, and flags misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset (MIPS text base)
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  byte address of request, always word-aligned
- imem_ack  input  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- if_valid  output  1  FIFO head valid toward decode
- if_instr  output  32  FIFO head instruction
- if_pc  output  32  byte address of if_instr
- if_ready  input  1  decode accepts head this cycle
- redirect  input  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  input  32  new fetch address
- fetch_err  output  1  sticky: misaligned redirect target

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, pc=RESET_PC, FIFO empty, state=RUN.
- Memory handshake: at most one outstanding request. Once raised, imem_req and imem_addr stay stable until the cycle imem_ack=1. imem_ack may arrive in the same cycle as req (zero wait). imem_ack with imem_req=0 is ignored.
- Issue rule: raise a request only when (fifo_count + outstanding) < DEPTH. The FIFO never overflows.
- On ack in state RUN: push {pc, rdata}, then pc <= pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
- Decode handshake: a pop occurs when if_valid && if_ready. if_instr/if_pc hold stable while if_valid && !if_ready. Push and pop in the same cycle are both performed.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect hit with a request outstanding and no ack in that cycle. Keep the old req/addr until ack, discard the data, then go to RUN at the saved redirect target.
  - ERR: fetch_err=1, no requests, FIFO empty. Only a redirect or reset exits ERR.
- Redirect (highest priority):
  - FIFO is flushed at the edge. A pop in the same cycle still counts as accepted by decode.
  - Ack in the same cycle has its data discarded.
  - If redirect_pc[1:0]!=0: go to ERR. Outstanding req (if any) drains first; fetch_err rises once the FIFO and memory are idle.
  - Otherwise pc <= redirect_pc and fetch_err clears.
  - A redirect during DRAIN replaces the saved target.
- Reset mid-operation: all state returns to reset values immediately (async). A pending memory ack after reset is ignored.

## Timing
- Earliest request: first rising edge after rst_n deasserts. imem_req=1, imem_addr=RESET_PC in the following cycle.
- Ack in cycle N: if_valid=1 with that word in cycle N+1 (1-cycle fill latency, registered FIFO output).
- Zero-wait memory and always-ready decode: one instruction per cycle sustained.
- Redirect in cycle N (no outstanding req, or ack in cycle N): imem_addr=redirect_pc in cycle N+1, and the first redirected if_valid no earlier than N+2.
- Redirect with an outstanding req: a one-ack drain is added before the new address is issued.
- if_valid goes 0 in the cycle after a redirect edge.

## Test plan
- Reset then zero-wait memory returning addr-derived words, if_ready=1 → if_pc sequence 0x00400000, 0x00400004, 0x00400008… one per cycle, if_instr matching each address.
- if_ready=0 for 6 cycles → exactly DEPTH=2 entries buffered, imem_req=0 while full, head stable. Release → in-order delivery with no loss or duplicates.
- Memory with 3-cycle ack delay, redirect to 0x00400100 in the wait cycle → old addr held until ack, that word never appears on if_instr, next request addr=0x00400100.
- Redirect to 0x00400102 → fetch_err=1, imem_req stays 0. Then redirect to 0x00400200 → fetch_err=0 and fetch resumes at 0x00400200.
- Redirect to 0xFFFFFFF8 → fetched addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
- Assert rst_n=0 with req outstanding and FIFO full → all outputs at reset values immediately. An ack one cycle later pushes nothing.
